operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
Parametrised keypad operand capture unit for the calculator datapath. It converts decoded keypad codes into multi-digit BCD operands for NUM_OPERANDS operand registers, replacing the fixed two-operand single-digit capture. Supports operand advance, backspace, clear and a done/lock state. It sits between the keypad decoder and the ALU/seven-segment display drivers.

Parameters:
NUM_OPERANDS, 2, number of operand registers (≥2)
DIGITS, 4, BCD digits per operand (≥1)
IDX_W, 1, width of active operand index; 2**IDX_W ≥ NUM_OPERANDS
CNT_W, 3, width of digit counter; 2**CNT_W > DIGITS

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
key_valid  in  1  key_code valid this cycle; one-cycle strobe per key press
key_code  in  4  0–9 digit; B backspace; C next operand; D done; F clear; A, E ignored
operands  out  NUM_OPERANDS*DIGITS*4  operand i at [i*DIGITS*4 +: DIGITS*4], most significant digit highest
digit_count  out  CNT_W  digits entered in active operand
active_idx  out  IDX_W  operand currently being entered
op_update  out  NUM_OPERANDS  one-cycle pulse per operand whose value changed, or refresh
overflow  out  1  one-cycle pulse when a digit is rejected because the operand is full
done  out  1  high in DONE state

Behaviour:
- One clock; reset is asynchronous and active-high. On assertion, immediately: all operands = 0, digit counters = 0, active_idx = 0, state = ENTRY, done = 0, overflow = 0, op_update = 0.
- Init refresh: on the first rising edge after reset deasserts, op_update = all ones for exactly one cycle. No key is processed on that edge.
- All outputs are registered. A key sampled at edge N is reflected on the outputs after edge N. Pulses are high for the cycle after edge N only. key_valid low means no state change.
- Each operand has its own digit counter. digit_count shows the active operand's counter.
- FSM states: ENTRY, DONE.
- ENTRY, digit d (0–9):
  - If count == 0 and d == 0: no change, no pulse (leading zero suppressed).
  - Else if count < DIGITS: operand = (operand << 4) | d, truncated to DIGITS*4 bits; count += 1; op_update[active] pulses.
  - Else (full): operand unchanged; overflow pulses; no op_update.
- ENTRY, B (backspace): if count > 0, operand >>= 4 and count -= 1, and op_update[active] pulses. If count == 0: nothing happens.
- ENTRY, F (clear): active operand = 0, count = 0, op_update[active] pulses. The pulse fires even if the operand was already 0.
- ENTRY, C (next):
  - If active_idx < NUM_OPERANDS-1: active_idx += 1. The target operand is not cleared.
  - Else: go to DONE.
  - No op_update in either case.
- ENTRY, D: go to DONE; done = 1 from the next cycle.
- DONE: every code except F is ignored, including overflow detection.
- DONE, F: clear all operands and counters, active_idx = 0, return to ENTRY, done = 0, op_update = all ones for one cycle.
- Codes A and E are ignored in both states.
- Reset mid-operation: asynchronous clear takes priority over everything. Any pending pulse is dropped.
- Never produced: non-BCD digit values, counters above DIGITS, active_idx ≥ NUM_OPERANDS.

Test Plan:
- Reset, release -> op_update = 2'b11 for one cycle, then 0; operands = 0; active_idx = 0; done = 0.
- Keys 0,1,2,3 into operand 0 -> leading 0 ignored; operand0 = 16'h0123, digit_count = 3; op_update[0] pulses three times.
- Keys 9,8,7,6,5 (DIGITS = 4) -> operand0 = 16'h9876, digit_count = 4; overflow pulses once on the 5; then B -> operand0 = 16'h0987, digit_count = 3.
- Keys 4, C, 7, C -> operand0 = 4, operand1 = 7, active_idx moves 0 -> 1, then done = 1; a subsequent digit 5 in DONE changes nothing.
- In DONE, key F -> all operands 0, active_idx = 0, done = 0, op_update = 2'b11 one cycle.
- Assert reset asynchronously between clock edges, mid-entry with operand0 = 16'h0012 -> outputs clear before the next edge; no pulse after release other than the init refresh.

Source files
------------

// File: rtl/operand_entry_if.sv
// operand_entry_if: keypad-to-operand bus between the keypad decoder and the capture unit
// Ports (slave = capture unit):
//   key_valid/key_code  in   one-cycle key strobe and 4-bit decoded key
//   operands            out  NUM_OPERANDS packed BCD operands, operand i at [i*DIGITS*4 +: DIGITS*4]
//   digit_count         out  digits entered in the active operand
//   active_idx          out  operand currently being entered
//   op_update           out  per-operand change/refresh pulse
//   overflow            out  pulse when a digit is rejected on a full operand
//   done                out  high while entry is locked
interface operand_entry_if #(
  parameter int NUM_OPERANDS = 2,
  parameter int DIGITS = 4,
  parameter int IDX_W = 1,
  parameter int CNT_W = 3
);
  logic key_valid;
  logic [3:0] key_code;
  logic [NUM_OPERANDS*DIGITS*4-1:0] operands;
  logic [CNT_W-1:0] digit_count;
  logic [IDX_W-1:0] active_idx;
  logic [NUM_OPERANDS-1:0] op_update;
  logic overflow;
  logic done;
  modport master (
    output key_valid, key_code,
    input operands, digit_count, active_idx, op_update, overflow, done
  );
  modport slave (
    input key_valid, key_code,
    output operands, digit_count, active_idx, op_update, overflow, done
  );
endinterface

// File: rtl/operand_entry.sv
// operand_entry: converts keypad codes into multi-digit BCD operands with advance/backspace/clear/done
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    operand_entry_if.slave: key_valid/key_code in; operands, digit_count,
//          active_idx, op_update, overflow, done out (all registered)
module operand_entry #(
  parameter int NUM_OPERANDS = 2,
  parameter int DIGITS = 4,
  parameter int IDX_W = 1,
  parameter int CNT_W = 3
) (
  input logic clk,
  input logic reset,
  operand_entry_if.slave bus
);
  localparam int W = DIGITS * 4;
  typedef enum logic {ENTRY, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] opnd_q [NUM_OPERANDS];
  logic [W-1:0] opnd_d [NUM_OPERANDS];
  logic [CNT_W-1:0] cnt_q [NUM_OPERANDS];
  logic [CNT_W-1:0] cnt_d [NUM_OPERANDS];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic init_q, init_d;
  logic [NUM_OPERANDS-1:0] upd_q, upd_d;
  logic ovf_q, ovf_d;
  logic [W-1:0] cur;
  logic [CNT_W-1:0] cur_cnt;
  logic digit;
  assign cur = opnd_q[idx_q];
  assign cur_cnt = cnt_q[idx_q];
  assign digit = bus.key_code <= 4'd9;
  always_comb begin
    opnd_d = opnd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    state_d = state_q;
    init_d = 1'b0;
    upd_d = '0;
    ovf_d = 1'b0;
    // init_q marks the first edge after reset release: refresh only, key ignored
    if (init_q) upd_d = '1;
    else if (bus.key_valid && state_q == DONE) begin
      if (bus.key_code == 4'hF) begin
        for (int i = 0; i < NUM_OPERANDS; i++) begin
          opnd_d[i] = '0;
          cnt_d[i] = '0;
        end
        idx_d = '0;
        state_d = ENTRY;
        upd_d = '1;
      end
    end else if (bus.key_valid) begin
      if (digit) begin
        if (cur_cnt >= CNT_W'(DIGITS)) ovf_d = 1'b1;
        else if (cur_cnt != '0 || bus.key_code != 4'd0) begin
          opnd_d[idx_q] = (cur << 4) | W'(bus.key_code);
          cnt_d[idx_q] = cur_cnt + 1'b1;
          upd_d[idx_q] = 1'b1;
        end
      end else begin
        case (bus.key_code)
          4'hB: if (cur_cnt != '0) begin
            opnd_d[idx_q] = cur >> 4;
            cnt_d[idx_q] = cur_cnt - 1'b1;
            upd_d[idx_q] = 1'b1;
          end
          4'hC: if (idx_q == IDX_W'(NUM_OPERANDS - 1)) state_d = DONE;
                else idx_d = idx_q + 1'b1;
          4'hD: state_d = DONE;
          4'hF: begin
            opnd_d[idx_q] = '0;
            cnt_d[idx_q] = '0;
            upd_d[idx_q] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTRY;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        opnd_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      idx_q <= '0;
      init_q <= 1'b1;
      upd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q <= opnd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      init_q <= init_d;
      upd_q <= upd_d;
      ovf_q <= ovf_d;
    end
  end
  for (genvar i = 0; i < NUM_OPERANDS; i++) begin : g_ops
    assign bus.operands[i*W +: W] = opnd_q[i];
  end
  assign bus.digit_count = cur_cnt;
  assign bus.active_idx = idx_q;
  assign bus.op_update = upd_q;
  assign bus.overflow = ovf_q;
  assign bus.done = state_q == DONE;
endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: self-checking bench for operand_entry against a decimal-value reference model
module tb_operand_entry;
  localparam int NP = 2;
  localparam int DG = 4;
  localparam int IW = 1;
  localparam int CW = 3;
  localparam int W = DG * 4;
  logic clk = 1'b0;
  logic reset;
  operand_entry_if #(.NUM_OPERANDS(NP), .DIGITS(DG), .IDX_W(IW), .CNT_W(CW)) bus();
  operand_entry #(.NUM_OPERANDS(NP), .DIGITS(DG), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int mval [NP];
  int midx;
  bit mdone;
  logic [NP-1:0] eupd;
  logic eovf;
  function automatic int ndig(int v);
    int n = 0;
    while (v > 0) begin
      n++;
      v /= 10;
    end
    return n;
  endfunction
  function automatic logic [NP*W-1:0] exp_ops();
    logic [NP*W-1:0] r = '0;
    for (int i = 0; i < NP; i++) begin
      int v = mval[i];
      for (int k = 0; k < DG; k++) begin
        r[i*W + k*4 +: 4] = 4'(v % 10);
        v /= 10;
      end
    end
    return r;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NP; i++) mval[i] = 0;
    midx = 0;
    mdone = 1'b0;
  endtask
  task automatic model_key(input logic [3:0] c);
    int n;
    eupd = '0;
    eovf = 1'b0;
    n = ndig(mval[midx]);
    if (mdone) begin
      if (c == 4'hF) begin
        model_reset();
        eupd = '1;
      end
    end else if (c <= 4'd9) begin
      if (n == DG) eovf = 1'b1;
      else if (!(n == 0 && c == 0)) begin
        mval[midx] = mval[midx] * 10 + int'(c);
        eupd[midx] = 1'b1;
      end
    end else if (c == 4'hB) begin
      if (mval[midx] > 0) begin
        mval[midx] /= 10;
        eupd[midx] = 1'b1;
      end
    end else if (c == 4'hF) begin
      mval[midx] = 0;
      eupd[midx] = 1'b1;
    end else if (c == 4'hC) begin
      if (midx < NP - 1) midx++;
      else mdone = 1'b1;
    end else if (c == 4'hD) mdone = 1'b1;
  endtask
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code = c;
    model_key(c);
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.operands !== '0 || bus.digit_count !== '0 || bus.active_idx !== '0 ||
        bus.done !== 1'b0 || bus.overflow !== 1'b0 || bus.op_update !== '0) begin
      errors++;
      $display("FAIL reset_state ops=%h cnt=%0d idx=%0d done=%b ovf=%b upd=%b", bus.operands,
               bus.digit_count, bus.active_idx, bus.done, bus.overflow, bus.op_update);
    end
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code = 4'h7;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    checks++;
    if (bus.op_update !== 2'b11 || bus.operands !== '0 || bus.digit_count !== '0) begin
      errors++;
      $display("FAIL init_refresh upd=%b ops=%h cnt=%0d want upd=11 ops=0 cnt=0", bus.op_update,
               bus.operands, bus.digit_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.op_update !== 2'b00) begin
      errors++;
      $display("FAIL refresh_end upd=%b want 00", bus.op_update);
    end
  endtask
  task automatic test_digits();
    int pulses = 0;
    press(4'h0);
    checks++;
    if (bus.op_update !== 2'b00 || bus.operands !== '0) begin
      errors++;
      $display("FAIL leading_zero upd=%b ops=%h want 00/0", bus.op_update, bus.operands);
    end
    for (int i = 1; i <= 3; i++) begin
      press(4'(i));
      if (bus.op_update === 2'b01) pulses++;
    end
    checks++;
    if (bus.operands[15:0] !== 16'h0123 || bus.digit_count !== 3'd3 || pulses != 3) begin
      errors++;
      $display("FAIL digits op0=%h cnt=%0d pulses=%0d want 0123/3/3", bus.operands[15:0],
               bus.digit_count, pulses);
    end
  endtask
  task automatic test_overflow_backspace();
    int ovfs = 0;
    press(4'hF);
    checks++;
    if (bus.op_update !== 2'b01 || bus.operands[15:0] !== 16'h0 || bus.digit_count !== 3'd0) begin
      errors++;
      $display("FAIL clear upd=%b op0=%h cnt=%0d want 01/0/0", bus.op_update, bus.operands[15:0],
               bus.digit_count);
    end
    for (int i = 9; i >= 5; i--) begin
      press(4'(i));
      if (bus.overflow === 1'b1) ovfs++;
    end
    checks++;
    if (bus.operands[15:0] !== 16'h9876 || bus.digit_count !== 3'd4 || ovfs != 1 ||
        bus.overflow !== 1'b1 || bus.op_update !== 2'b00) begin
      errors++;
      $display("FAIL overflow op0=%h cnt=%0d ovfs=%0d ovf=%b upd=%b want 9876/4/1/1/00",
               bus.operands[15:0], bus.digit_count, ovfs, bus.overflow, bus.op_update);
    end
    press(4'hB);
    checks++;
    if (bus.operands[15:0] !== 16'h0987 || bus.digit_count !== 3'd3 || bus.overflow !== 1'b0 ||
        bus.op_update !== 2'b01) begin
      errors++;
      $display("FAIL backspace op0=%h cnt=%0d ovf=%b upd=%b want 0987/3/0/01", bus.operands[15:0],
               bus.digit_count, bus.overflow, bus.op_update);
    end
  endtask
  task automatic test_next_done();
    press(4'hF);
    press(4'h4);
    press(4'hC);
    checks++;
    if (bus.active_idx !== 1'b1 || bus.op_update !== 2'b00 || bus.digit_count !== 3'd0) begin
      errors++;
      $display("FAIL next idx=%0d upd=%b cnt=%0d want 1/00/0", bus.active_idx, bus.op_update,
               bus.digit_count);
    end
    press(4'h7);
    press(4'hC);
    checks++;
    if (bus.done !== 1'b1 || bus.operands !== {16'h0007, 16'h0004}) begin
      errors++;
      $display("FAIL last_next done=%b ops=%h want 1/00070004", bus.done, bus.operands);
    end
    press(4'h5);
    checks++;
    if (bus.done !== 1'b1 || bus.operands !== {16'h0007, 16'h0004} || bus.op_update !== 2'b00 ||
        bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL done_ignore done=%b ops=%h upd=%b ovf=%b want 1/00070004/00/0", bus.done,
               bus.operands, bus.op_update, bus.overflow);
    end
  endtask
  task automatic test_done_clear();
    press(4'hF);
    checks++;
    if (bus.operands !== '0 || bus.active_idx !== '0 || bus.done !== 1'b0 ||
        bus.op_update !== 2'b11 || bus.digit_count !== '0) begin
      errors++;
      $display("FAIL done_clear ops=%h idx=%0d done=%b upd=%b want 0/0/0/11", bus.operands,
               bus.active_idx, bus.done, bus.op_update);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.op_update !== 2'b00) begin
      errors++;
      $display("FAIL done_clear_pulse upd=%b want 00", bus.op_update);
    end
  endtask
  task automatic test_async_reset();
    press(4'h1);
    press(4'h2);
    checks++;
    if (bus.operands[15:0] !== 16'h0012 || bus.digit_count !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset op0=%h cnt=%0d want 0012/2", bus.operands[15:0], bus.digit_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.operands !== '0 || bus.digit_count !== '0 || bus.op_update !== '0 ||
        bus.done !== 1'b0 || bus.active_idx !== '0) begin
      errors++;
      $display("FAIL async_reset ops=%h cnt=%0d upd=%b want all 0", bus.operands,
               bus.digit_count, bus.op_update);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.op_update !== 2'b11) begin
      errors++;
      $display("FAIL reset_refresh upd=%b want 11", bus.op_update);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.op_update !== 2'b00 || bus.operands !== '0) begin
      errors++;
      $display("FAIL post_reset upd=%b ops=%h want 00/0", bus.op_update, bus.operands);
    end
  endtask
  task automatic test_random();
    logic [3:0] extra [8] = '{4'hB, 4'hC, 4'hD, 4'hF, 4'hA, 4'hE, 4'hB, 4'hF};
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        bus.key_code = 4'($urandom);
        eupd = '0;
        eovf = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        int r = int'($urandom_range(0, 19));
        press(r < 12 ? 4'(r % 10) : extra[r - 12]);
      end
      checks++;
      if (bus.operands !== exp_ops() || bus.digit_count !== CW'(ndig(mval[midx])) ||
          bus.active_idx !== IW'(midx) || bus.done !== mdone || bus.op_update !== eupd ||
          bus.overflow !== eovf) begin
        errors++;
        $display("FAIL random step=%0d ops=%h/%h cnt=%0d/%0d idx=%0d/%0d done=%b/%b upd=%b/%b ovf=%b/%b",
                 n, bus.operands, exp_ops(), bus.digit_count, ndig(mval[midx]), bus.active_idx,
                 midx, bus.done, mdone, bus.op_update, eupd, bus.overflow, eovf);
      end
    end
  endtask
  initial begin
    test_reset();
    test_digits();
    test_overflow_backspace();
    test_next_done();
    test_done_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
